paddsb_seq: RTL and testbench

Multi-cycle sequencer for the parallel sub-word saturating add (PADDSB): it adds two 16-bit operands as four independent signed 4-bit lanes by time-multiplexing one shared `addsub_4bit` saturating adder, one nibble per cycle. It sits beside the ALU in the execute stage, is started by the decoder/control for PADDSB, and returns a 16-bit result plus per-lane saturation flags.

---
 rtl/paddsb_pkg.sv | 15 +
 rtl/addsub_4bit.sv | 24 ++
 rtl/paddsb_seq.sv | 79 +++++++
 tb/tb_paddsb_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/paddsb_pkg.sv
// Shared constants and state encoding for the PADDSB sequencer.
package paddsb_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 4;
    localparam int WORD_W = LANES * LANE_W;
    localparam int IDX_W  = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_4bit.sv
// Signed 4-bit saturating adder/subtractor.
// Overflow is carry-out of bit 3 XOR carry into bit 3.
module addsub_4bit (
    input  logic       sub,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       ovfl
);

    logic [3:0] bx;
    logic [3:0] raw;
    logic       c3;
    logic       c4;

    assign bx = sub ? ~b : b;
    assign {c3, raw[2:0]} = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, sub};
    assign {c4, raw[3]}   = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, c3};
    assign ovfl = c4 ^ c3;

    // On overflow the true result has the sign of a, so clamp toward it.
    assign sum = ovfl ? (a[3] ? 4'b1000 : 4'b0111) : raw;

endmodule

// File: rtl/paddsb_seq.sv
// PADDSB sequencer: four signed nibble lanes summed one per cycle through a
// single shared saturating adder; result and per-lane saturation flags out.
module paddsb_seq
    import paddsb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic [LANES-1:0]  sat_mask
);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  a_reg;
    logic [WORD_W-1:0]  b_reg;
    logic [LANE_W-1:0]  lane_a;
    logic [LANE_W-1:0]  lane_b;
    logic [LANE_W-1:0]  lane_sum;
    logic               lane_ovfl;
    logic               accept;
    logic               last;

    assign lane_a = a_reg[idx*LANE_W +: LANE_W];
    assign lane_b = b_reg[idx*LANE_W +: LANE_W];
    assign last   = (idx == IDX_W'(LANES - 1));

    // abort wins over start in every state.
    assign accept = start && !abort && (state == ST_IDLE || state == ST_DONE);

    addsub_4bit u_add (
        .sub  (1'b0),
        .a    (lane_a),
        .b    (lane_b),
        .sum  (lane_sum),
        .ovfl (lane_ovfl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            result   <= '0;
            sat_mask <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else if (accept) begin
            state    <= ST_RUN;
            idx      <= '0;
            a_reg    <= a;
            b_reg    <= b;
            result   <= '0;
            sat_mask <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    result[idx*LANE_W +: LANE_W] <= lane_sum;
                    sat_mask[idx]                <= lane_ovfl;
                    idx                          <= idx + 1'b1;
                    if (last) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_paddsb_seq.sv
// Directed bench for paddsb_seq with hand-computed lane sums.
module tb_paddsb_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  sat_mask;

    int total = 0;
    int bad   = 0;

    paddsb_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .sat_mask (sat_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start an op, then count busy cycles until done within a bound.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] er, input logic [3:0] em);
        int n;
        int bc;
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; bc = 0;
        while (!done && n < 10) begin
            if (busy) bc++;
            tick();
            n++;
        end
        check({tag, "_lat"},  16'(n),  16'd4);
        check({tag, "_busy"}, 16'(bc), 16'd4);
        check({tag, "_done"}, {15'd0, done}, 16'd1);
        check({tag, "_res"},  result, er);
        check({tag, "_mask"}, {12'd0, sat_mask}, {12'd0, em});
        tick();
        check({tag, "_idle"}, {14'd0, busy, done}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
        tick(); tick();
        check("rst_outs", {12'd0, busy, done, 2'b00}, 16'd0);
        check("rst_res", result, 16'h0000);
        check("rst_mask", {12'd0, sat_mask}, 16'h0000);
        #2 rst_n = 1'b1;
        tick();
        check("idle_after_rst", {14'd0, busy, done}, 16'd0);

        run_op("nosat", 16'h1234, 16'h1111, 16'h2345, 4'h0);
        run_op("possat", 16'h7777, 16'h1111, 16'h7777, 4'hF);
        run_op("mixed", 16'h8F00, 16'h8F00, 16'h8E00, 4'h8);

        // Start during RUN ignored, then back-to-back start in DONE.
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        tick();
        check("ign_busy", {15'd0, busy}, 16'd1);
        a = 16'h7777; b = 16'h7777;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("ign_done", {15'd0, done}, 16'd1);
        check("ign_res", result, 16'h2345);
        check("ign_mask", {12'd0, sat_mask}, 16'h0);
        a = 16'h8F00; b = 16'h8F00; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", {15'd0, busy}, 16'd1);
        tick(); tick(); tick();
        check("b2b_notyet", {15'd0, done}, 16'd0);
        tick();
        check("b2b_done", {15'd0, done}, 16'd1);
        check("b2b_res", result, 16'h8E00);
        check("b2b_mask", {12'd0, sat_mask}, 16'h8);
        tick();

        // Abort in second RUN cycle: only lane 0 written.
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {14'd0, busy, done}, 16'd0);
        check("abort_res", result, 16'h0005);
        check("abort_mask", {12'd0, sat_mask}, 16'h0);
        tick(); tick(); tick(); tick();
        check("abort_nodone", {14'd0, busy, done}, 16'd0);

        // Asynchronous reset mid-RUN.
        a = 16'h7777; b = 16'h1111; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs", {14'd0, busy, done}, 16'd0);
        check("arst_res", result, 16'h0000);
        check("arst_mask", {12'd0, sat_mask}, 16'h0);
        #1 rst_n = 1'b1;
        tick();
        check("arst_idle", {14'd0, busy, done}, 16'd0);
        tick(); tick(); tick(); tick();
        check("arst_nodone", {14'd0, busy, done}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
